// File: rtl/led_pwm_pkg.sv
// Shared types and default widths for the LED PWM effect stages.
package led_pwm_pkg;

    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned RATE_W  = 4;

    typedef enum logic {
        TRACK = 1'b0,
        HOLD  = 1'b1
    } fade_state_e;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } goal_sel_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the PWM period strobe by 2^rate to produce a step strobe.
module tick_prescaler #(
    parameter int unsigned RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_tick,
    input  logic [RATE_W-1:0] rate,
    output logic              step
);

    // Enough bits to hold 2^(2^RATE_W - 1) - 1, the largest interval.
    localparam int unsigned PRE_W = (1 << RATE_W) - 1;

    logic [PRE_W-1:0] count;
    logic [PRE_W-1:0] limit;

    // At the largest rate the shift drops out of range and the subtract wraps to all ones.
    assign limit = (PRE_W'(1) << rate) - PRE_W'(1);

    // Unsigned >= so a shrinking rate never strands the count above the limit.
    assign step = period_tick && (count >= limit);

    // Tick counter, cleared whenever a step is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (period_tick) begin
            if (count >= limit) begin
                count <= '0;
            end else begin
                count <= count + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_fade_sequencer.sv
// Walks an LED brightness level toward a target, optionally breathing
// between 0 and the target with dwell periods at the peak and trough.
module led_fade_sequencer #(
    parameter int unsigned WIDTH      = led_pwm_pkg::LEVEL_W,
    parameter int unsigned RATE_W     = led_pwm_pkg::RATE_W,
    parameter int unsigned HOLD_STEPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_tick,
    input  logic [WIDTH-1:0]  target,
    input  logic [RATE_W-1:0] rate,
    input  logic              breathe,
    output logic [WIDTH-1:0]  level,
    output logic              at_goal,
    output logic              falling,
    output logic              cycle_done
);

    import led_pwm_pkg::*;

    localparam int unsigned HOLD_W = 8;
    // The step that enters HOLD counts as the first dwell step, so HOLD
    // leaves once the counter reaches HOLD_STEPS-1.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    fade_state_e       state_q, state_nx;
    goal_sel_e         goal_sel_q, goal_sel_nx;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_nx, hold_inc;
    logic [WIDTH-1:0]  level_nx;
    logic [WIDTH-1:0]  goal, goal_nx;
    logic              falling_nx, done_nx;
    logic              step;

    // Period-paced step strobe.
    tick_prescaler #(
        .RATE_W (RATE_W)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .period_tick (period_tick),
        .rate        (rate),
        .step        (step)
    );

    // Current goal and its comparison against the level.
    assign goal    = (!breathe || goal_sel_q == HIGH) ? target : '0;
    assign at_goal = (level == goal);
    assign hold_inc = hold_cnt_q + HOLD_W'(1);

    // Next-state, level datapath and hold counter.
    always_comb begin
        state_nx    = state_q;
        goal_sel_nx = goal_sel_q;
        hold_cnt_nx = hold_cnt_q;
        level_nx    = level;
        done_nx     = 1'b0;

        // Leaving breathe snaps back to plain tracking toward the target.
        if (!breathe) begin
            state_nx    = TRACK;
            goal_sel_nx = HIGH;
            hold_cnt_nx = '0;
        end

        if (step) begin
            if (!breathe || state_q == TRACK) begin
                if (level < goal) begin
                    level_nx = level + WIDTH'(1);
                end else if (level > goal) begin
                    level_nx = level - WIDTH'(1);
                end else if (breathe) begin
                    state_nx    = HOLD;
                    hold_cnt_nx = '0;
                end
            end else begin
                if (hold_inc >= HOLD_LAST) begin
                    state_nx    = TRACK;
                    hold_cnt_nx = '0;
                    goal_sel_nx = (goal_sel_q == HIGH) ? LOW : HIGH;
                    done_nx     = (goal_sel_q == LOW);
                end else begin
                    hold_cnt_nx = hold_inc;
                end
            end
        end

        goal_nx    = (!breathe || goal_sel_nx == HIGH) ? target : '0;
        falling_nx = (goal_nx < level_nx) || (breathe && goal_nx == '0);
    end

    // State, level and registered flag outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TRACK;
            goal_sel_q <= HIGH;
            hold_cnt_q <= '0;
            level      <= '0;
            falling    <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state_q    <= state_nx;
            goal_sel_q <= goal_sel_nx;
            hold_cnt_q <= hold_cnt_nx;
            level      <= level_nx;
            falling    <= falling_nx;
            cycle_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Scoreboard bench for led_fade_sequencer: each tick pushes the reference
// model's expected outputs; a monitor compares them one clock later.
module tb_led_fade_sequencer;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned RATE_W     = 4;
    localparam int unsigned HOLD_STEPS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              period_tick;
    logic [WIDTH-1:0]  target;
    logic [RATE_W-1:0] rate;
    logic              breathe;
    logic [WIDTH-1:0]  level;
    logic              at_goal;
    logic              falling;
    logic              cycle_done;

    led_fade_sequencer #(
        .WIDTH      (WIDTH),
        .RATE_W     (RATE_W),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .period_tick (period_tick),
        .target      (target),
        .rate        (rate),
        .breathe     (breathe),
        .level       (level),
        .at_goal     (at_goal),
        .falling     (falling),
        .cycle_done  (cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int level;
        int at_goal;
        int falling;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_pulses = 0;

    // Reference model: level, tick count since last step, dwell progress.
    int m_level;
    int m_ticks;
    int m_dwell;
    bit m_holding;
    bit m_high;
    bit m_done;

    logic seen;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_level   = 0;
        m_ticks   = 0;
        m_dwell   = 0;
        m_holding = 1'b0;
        m_high    = 1'b1;
        m_done    = 1'b0;
    endfunction

    function automatic int model_goal();
        return (!breathe || m_high) ? int'(target) : 0;
    endfunction

    // One PWM period: every 2^rate periods the level moves one count toward
    // the goal, or a breathe dwell advances.
    function automatic void model_tick();
        int goal;
        m_done = 1'b0;
        if (m_ticks + 1 < (1 << rate)) begin
            m_ticks++;
            return;
        end
        m_ticks = 0;
        if (!breathe) begin
            m_holding = 1'b0;
            m_high    = 1'b1;
        end
        goal = model_goal();
        if (!m_holding) begin
            if (m_level < goal)       m_level++;
            else if (m_level > goal)  m_level--;
            else if (breathe) begin
                m_holding = 1'b1;
                m_dwell   = 1;
            end
        end else begin
            m_dwell++;
            if (m_dwell >= int'(HOLD_STEPS)) begin
                m_holding = 1'b0;
                m_high    = !m_high;
                m_done    = m_high;
            end
        end
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        int   goal;
        goal      = model_goal();
        e.level   = m_level;
        e.at_goal = (m_level == goal) ? 1 : 0;
        e.falling = (goal < m_level || (breathe && goal == 0)) ? 1 : 0;
        e.done    = m_done ? 1 : 0;
        return e;
    endfunction

    // Marks the cycle after a sampled tick as one where outputs are due.
    always @(posedge clk or posedge rst) begin
        if (rst) seen <= 1'b0;
        else     seen <= period_tick;
    end

    // Monitor: compare against the scoreboard whenever a tick's result is visible.
    always @(negedge clk) begin
        if (!rst) begin
            if (seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: level %0d with no expectation queued", level);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("level", int'(level), e.level);
                    check("at_goal", int'(at_goal), e.at_goal);
                    check("falling", int'(falling), e.falling);
                    check("cycle_done", int'(cycle_done), e.done);
                    if (cycle_done) done_pulses++;
                end
            end else begin
                check("cycle_done_idle", int'(cycle_done), 0);
            end
        end
    end

    task automatic do_tick(input int gap);
        @(negedge clk);
        period_tick = 1'b1;
        model_tick();
        exp_q.push_back(model_outputs());
        @(negedge clk);
        period_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(2);
    endtask

    task automatic set_in(input int t, input int r, input bit b);
        @(negedge clk);
        if (breathe && !b) begin
            m_holding = 1'b0;
            m_high    = 1'b1;
        end
        target  = WIDTH'(t);
        rate    = RATE_W'(r);
        breathe = b;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_level", int'(level), 0);
        check("rst_cycle_done", int'(cycle_done), 0);
        check("rst_falling", int'(falling), 0);
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses_before;
        rst         = 1'b1;
        period_tick = 1'b0;
        target      = '0;
        rate        = '0;
        breathe     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_level", int'(level), 0);
        check("reset_falling", int'(falling), 0);
        check("reset_at_goal", int'(at_goal), 1);

        // Plain fade up at one step per tick.
        set_in(5, 0, 1'b0);
        ticks(7);
        check("fade_up_final", int'(level), 5);

        // Slow fade down, one step every 4 ticks.
        set_in(3, 2, 1'b0);
        ticks(9);
        check("fade_down_final", int'(level), 3);

        // Full breathe cycle from 0 to 4 and back.
        set_in(0, 0, 1'b0);
        ticks(4);
        pulses_before = done_pulses;
        set_in(4, 0, 1'b1);
        ticks(12);
        check("breathe_one_pulse", done_pulses - pulses_before, 1);
        check("breathe_trough", int'(level), 0);

        // Reverse mid-fade with no overshoot.
        set_in(20, 0, 1'b0);
        for (int i = 0; i < 40 && m_level < 10; i++) do_tick(1);
        set_in(6, 0, 1'b0);
        ticks(6);
        check("reverse_final", int'(level), 6);

        // Asynchronous reset mid-fade, then prescaler restarts from 0.
        set_in(200, 0, 1'b0);
        ticks(30);
        async_reset();
        set_in(200, 2, 1'b0);
        ticks(8);

        // Rate shrink with the prescaler well past the new limit.
        set_in(100, 7, 1'b0);
        for (int i = 0; i < 50; i++) do_tick(0);
        set_in(100, 0, 1'b0);
        ticks(5);

        // Breathe at target 0: dwell alternates, cycle_done still pulses.
        set_in(0, 0, 1'b0);
        ticks(110);
        pulses_before = done_pulses;
        set_in(0, 0, 1'b1);
        ticks(8);
        check("breathe_zero_pulses", done_pulses - pulses_before, 2);

        // Randomized input changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_in(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                                   : int'($urandom_range(0, 12)),
                       int'($urandom_range(0, 2)),
                       ($urandom_range(0, 2) != 0) ? breathe : bit'($urandom_range(0, 1)));
            end
            do_tick(int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
